// File: rtl/instr_encoder_if.sv
// Handshake and field bundle for instr_encoder.
//   master : operand producer / word consumer (drives bundle, clear, out_ready)
//   slave  : the encoder (drives in_ready, out_*, full, err)
interface instr_encoder_if #(
  parameter int AW = 6
);
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    mnem;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          full;
  logic          err;

  modport master (
    output clear, in_valid, mnem, rs, rt, rd, shamt, funct, imm, target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, full, err
  );

  modport slave (
    input  clear, in_valid, mnem, rs, rt, rd, shamt, funct, imm, target, out_ready,
    output in_ready, out_valid, out_instr, out_addr, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs mnemonic + operand fields into 32-bit
// machine words, each tagged with a sequential word address.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      instr_encoder_if.slave: in_valid/in_ready operand bundle,
//            out_valid/out_ready word + address, clear, full, err
module instr_encoder #(
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  instr_encoder_if.slave bus
);

  typedef enum logic [3:0] {
    M_RTYPE = 4'd0, M_LW  = 4'd1, M_SW  = 4'd2, M_BEQ = 4'd3, M_ADDI = 4'd4,
    M_J     = 4'd5, M_LUI = 4'd6, M_LI  = 4'd7, M_BLT = 4'd8
  } mnem_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          err_q, err_d;
  logic          vld_q, vld_d;
  logic [31:0]   instr_q, instr_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          legal, fire;
  logic [31:0]   enc;

  assign legal        = (bus.mnem <= 4'd8);
  // Output slot frees up in the same cycle it drains, so a full pipe still streams.
  assign bus.in_ready = ~full_q & ~bus.clear & (~vld_q | bus.out_ready);
  assign fire         = bus.in_valid & bus.in_ready;

  always_comb begin
    enc = 32'h0;
    case (mnem_e'(bus.mnem))
      M_RTYPE: enc = {6'b000000, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      M_LW:    enc = {6'b100011, bus.rs, bus.rt, bus.imm};
      M_SW:    enc = {6'b101011, bus.rs, bus.rt, bus.imm};
      M_BEQ:   enc = {6'b000100, bus.rs, bus.rt, bus.imm};
      M_ADDI:  enc = {6'b001000, bus.rs, bus.rt, bus.imm};
      M_J:     enc = {6'b000010, bus.target};
      M_LUI:   enc = {6'b001111, 5'b0, bus.rt, bus.imm};
      M_LI:    enc = {6'b010001, 5'b0, bus.rt, bus.imm};
      M_BLT:   enc = {6'b011111, bus.rs, bus.rt, bus.imm};
      default: enc = 32'h0;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    full_d  = full_q;
    err_d   = 1'b0;
    vld_d   = vld_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    if (bus.clear) begin
      // clear wins over any handshake; pending word is dropped
      cnt_d  = '0;
      full_d = 1'b0;
      vld_d  = 1'b0;
    end else begin
      if (vld_q && bus.out_ready) vld_d = 1'b0;
      if (fire) begin
        if (legal) begin
          vld_d   = 1'b1;
          instr_d = enc;
          addr_d  = cnt_q[AW-1:0];
          cnt_d   = cnt_q + 1'b1;
          full_d  = (cnt_d == DEPTH_C);
        end else begin
          // illegal bundle is swallowed: flag it, emit nothing
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;
  assign bus.full      = full_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int AW    = 6;
  localparam int DEPTH = 4;

  logic clk, reset_n;
  int   n_chk, n_err;

  instr_encoder_if #(.AW(AW)) bus ();

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoding straight from the opcode table, by arithmetic.
  int unsigned op_tab [9] = '{0, 35, 43, 4, 8, 2, 15, 17, 31};

  function automatic logic [31:0] ref_enc(input int m, input int rs, input int rt, input int rd,
                                          input int sh, input int fn, input int imm, input int tgt);
    int unsigned w;
    w = op_tab[m] * 32'h0400_0000;
    case (m)
      0:       w += rs * 2**21 + rt * 2**16 + rd * 2**11 + sh * 64 + fn;
      5:       w += tgt;
      6, 7:    w += rt * 2**16 + imm;
      default: w += rs * 2**21 + rt * 2**16 + imm;
    endcase
    return w;
  endfunction

  typedef struct { logic [31:0] word; int addr; } exp_t;
  exp_t q[$];
  int   m_cnt;
  bit   m_full, m_err;

  // Transaction-level scoreboard: inputs are stable from posedge+1 to the
  // next posedge, so the negedge sees exactly what the coming edge will act on.
  always @(negedge clk) begin
    bit exp_v, exp_rdy;
    if (!reset_n) begin
      chk("rst_ovld",  32'(bus.out_valid), 0);
      chk("rst_addr",  32'(bus.out_addr),  0);
      chk("rst_full",  32'(bus.full),      0);
      chk("rst_err",   32'(bus.err),       0);
      chk("rst_instr", bus.out_instr,      0);
      q.delete();
      m_cnt = 0; m_full = 0; m_err = 0;
    end else begin
      exp_v = (q.size() != 0);
      chk("ovld", 32'(bus.out_valid), 32'(exp_v));
      if (exp_v) begin
        chk("instr", bus.out_instr, q[0].word);
        chk("addr",  32'(bus.out_addr), 32'(q[0].addr));
      end
      chk("err",  32'(bus.err),  32'(m_err));
      chk("full", 32'(bus.full), 32'(m_full));
      exp_rdy = !m_full && !bus.clear && (!exp_v || bus.out_ready);
      chk("in_rdy", 32'(bus.in_ready), 32'(exp_rdy));
      m_err = 0;
      if (bus.clear) begin
        q.delete();
        m_cnt = 0; m_full = 0;
      end else begin
        if (exp_v && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && exp_rdy) begin
          if (bus.mnem <= 8) begin
            q.push_back('{ref_enc(int'(bus.mnem), int'(bus.rs), int'(bus.rt), int'(bus.rd),
                                  int'(bus.shamt), int'(bus.funct), int'(bus.imm), int'(bus.target)),
                          m_cnt});
            m_cnt++;
            if (m_cnt == DEPTH) m_full = 1;
          end else begin
            m_err = 1;
          end
        end
      end
    end
  end

  task automatic fields(input int rs, input int rt, input int rd, input int sh,
                        input int fn, input int imm, input int tgt);
    bus.rs = 5'(rs); bus.rt = 5'(rt); bus.rd = 5'(rd); bus.shamt = 5'(sh);
    bus.funct = 6'(fn); bus.imm = 16'(imm); bus.target = 26'(tgt);
  endtask

  task automatic rand_fields();
    fields($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // Present a bundle until accepted or budget runs out; returns at posedge+1.
  task automatic send(input logic [3:0] m, input int budget, input bit must, output bit acc);
    bit a;
    acc = 0;
    bus.mnem = m;
    bus.in_valid = 1'b1;
    for (int c = 0; c < budget && !acc; c++) begin
      @(negedge clk); a = bus.in_ready;
      @(posedge clk); #1; acc = a;
    end
    bus.in_valid = 1'b0;
    if (must && !acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
  endtask

  initial begin
    bit acc;
    logic [31:0] held;
    n_chk = 0; n_err = 0;
    reset_n = 1'b0;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.mnem = '0;
    rand_fields();

    // 1: reset with random inputs toggling
    repeat (3) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom); bus.mnem = 4'($urandom); bus.clear = 1'($urandom);
      bus.out_ready = 1'($urandom); rand_fields();
    end
    @(posedge clk); #1;
    reset_n = 1'b1; bus.in_valid = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b1;

    // 2: directed encodings
    fields(0, 8, 0, 0, 0, 5, 0);       send(4'd4, 3, 1, acc);
    @(negedge clk); chk("addi", bus.out_instr, 32'h2008_0005); chk("addi_addr", 32'(bus.out_addr), 0);
    @(posedge clk); #1;
    fields(8, 9, 0, 0, 0, 4, 0);       send(4'd1, 3, 1, acc);
    @(negedge clk); chk("lw", bus.out_instr, 32'h8D09_0004); chk("lw_addr", 32'(bus.out_addr), 1);
    @(posedge clk); #1;
    fields(8, 9, 10, 0, 32'h20, 0, 0); send(4'd0, 3, 1, acc);
    @(negedge clk); chk("rtype", bus.out_instr, 32'h0109_5020); chk("rtype_addr", 32'(bus.out_addr), 2);
    @(posedge clk); #1;
    fields(0, 0, 0, 0, 0, 0, 32'h10);  send(4'd5, 3, 1, acc);
    @(negedge clk); chk("j", bus.out_instr, 32'h0800_0010);
    chk("full_after4", 32'(bus.full), 1); chk("rdy_full", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    do_clear();

    // 3: back-pressure then streaming
    bus.out_ready = 1'b0;
    rand_fields(); send(4'd2, 3, 1, acc);
    @(negedge clk); held = bus.out_instr;
    @(posedge clk); #1;
    rand_fields(); bus.mnem = 4'd3; bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rdy", 32'(bus.in_ready), 0);
      chk("bp_stable", bus.out_instr, held);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_fields(); send(4'($urandom_range(0, 8)), 1, 1, acc);
    end
    repeat (2) @(posedge clk); #1;
    do_clear();

    // 4: full with DEPTH words, then clear restarts at 0
    for (int i = 0; i < 6; i++) begin
      rand_fields(); send(4'($urandom_range(0, 8)), 2, (i < 4), acc);
    end
    @(negedge clk); chk("full_set", 32'(bus.full), 1); chk("full_rdy", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    do_clear();
    @(negedge clk); chk("full_clr", 32'(bus.full), 0);
    @(posedge clk); #1;
    rand_fields(); send(4'd6, 2, 1, acc);
    @(negedge clk); chk("restart_addr", 32'(bus.out_addr), 0); chk("restart_v", 32'(bus.out_valid), 1);
    @(posedge clk); #1;
    do_clear();

    // 5: illegal between two legal words
    rand_fields(); send(4'd4, 2, 1, acc);
    rand_fields(); send(4'hF, 2, 1, acc);
    @(negedge clk); chk("err_pulse", 32'(bus.err), 1);
    @(posedge clk); #1;
    @(negedge clk); chk("err_clear", 32'(bus.err), 0);
    @(posedge clk); #1;
    rand_fields(); send(4'd8, 2, 1, acc);
    @(negedge clk); chk("ill_addr", 32'(bus.out_addr), 1);
    @(posedge clk); #1;
    do_clear();

    // 6: LI/BLT, then async reset while stalled
    fields(7, 3, 0, 0, 0, 32'h1234, 0); send(4'd7, 2, 1, acc);
    @(negedge clk); chk("li", bus.out_instr, 32'h4403_1234);
    @(posedge clk); #1;
    fields(1, 2, 0, 0, 0, 32'hFFFE, 0); send(4'd8, 2, 1, acc);
    @(negedge clk); chk("blt", bus.out_instr, 32'h7C22_FFFE);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    rand_fields(); send(4'd1, 2, 1, acc);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1 chk("async_rst_ovld", 32'(bus.out_valid), 0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1; bus.out_ready = 1'b1;

    // random streaming, scoreboard does the checking
    for (int i = 0; i < 2000; i++) begin
      bus.clear     = ($urandom_range(0, 9) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.mnem      = 4'($urandom_range(0, 11));
      rand_fields();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.clear = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
